// File: rtl/air_hockey.sv
// Two-player air hockey: 640x480 VGA timing, per-frame game state, pixel colouriser
// and a multiplexed four-digit score display, all on the 50 MHz board clock.
module air_hockey (
   input  logic       InputClock,
   input  logic       btns,
   input  logic       btnu,
   input  logic       btnd,
   input  logic       btnl,
   input  logic       btnr,
   output logic [2:0] red,
   output logic [2:0] green,
   output logic [1:0] blue,
   output logic       hsync,
   output logic       vsync,
   output logic [7:0] seg,
   output logic [3:0] an
);

   localparam logic [9:0] PAD_Y0   = 10'd208;
   localparam logic [9:0] PUCK_X0  = 10'd316;
   localparam logic [9:0] PUCK_Y0  = 10'd236;
   localparam logic [9:0] LPAD_X   = 10'd16;
   localparam logic [9:0] RPAD_X   = 10'd616;

   logic        pix_q, pix_d;
   logic [9:0]  hc_q, hc_d, vc_q, vc_d;
   logic        pix_tick, frame_tick;

   logic [9:0]  lpad_q, lpad_d, rpad_q, rpad_d;
   logic [9:0]  puck_x_q, puck_x_d, puck_y_q, puck_y_d;
   logic        vx_neg_q, vx_neg_d, vy_neg_q, vy_neg_d;
   logic [3:0]  p1_q, p1_d, p2_q, p2_d;
   logic        l_overlap, r_overlap, vx_next, vy_next;

   logic [2:0]  red_q, red_d, green_q, green_d;
   logic [1:0]  blue_q, blue_d;
   logic        hsync_q, hsync_d, vsync_q, vsync_d;
   logic        active, in_puck, in_lpad, in_rpad, in_border;

   logic [17:0] scan_q, scan_d;
   logic [7:0]  seg_q, seg_d;
   logic [3:0]  an_q, an_d;

   function automatic logic [9:0] move_paddle(input logic [9:0] y, input logic up, input logic dn);
      logic [9:0] r;
      r = y;
      if (up && !dn)
         r = (y <= 10'd12) ? 10'd8 : y - 10'd4;
      else if (dn && !up)
         r = (y >= 10'd404) ? 10'd408 : y + 10'd4;
      return r;
   endfunction

   function automatic logic [3:0] score_inc(input logic [3:0] s);
      return (s == 4'd9) ? 4'd0 : s + 4'd1;
   endfunction

   function automatic logic [7:0] seg_of(input logic [3:0] d);
      logic [7:0] r;
      case (d)
         4'd0:    r = 8'hC0;
         4'd1:    r = 8'hF9;
         4'd2:    r = 8'hA4;
         4'd3:    r = 8'hB0;
         4'd4:    r = 8'h99;
         4'd5:    r = 8'h92;
         4'd6:    r = 8'h82;
         4'd7:    r = 8'hF8;
         4'd8:    r = 8'h80;
         4'd9:    r = 8'h90;
         default: r = 8'hFF;
      endcase
      return r;
   endfunction

   // VGA counters advance on every second clock
   always_comb begin
      pix_d    = ~pix_q;
      pix_tick = pix_q;
      hc_d     = hc_q;
      vc_d     = vc_q;
      if (pix_tick) begin
         if (hc_q == 10'd799) begin
            hc_d = 10'd0;
            vc_d = (vc_q == 10'd524) ? 10'd0 : vc_q + 10'd1;
         end else begin
            hc_d = hc_q + 10'd1;
         end
      end
      frame_tick = pix_tick && (hc_q == 10'd639) && (vc_q == 10'd479);
   end

   always_comb begin
      lpad_d    = lpad_q;
      rpad_d    = rpad_q;
      puck_x_d  = puck_x_q;
      puck_y_d  = puck_y_q;
      vx_neg_d  = vx_neg_q;
      vy_neg_d  = vy_neg_q;
      p1_d      = p1_q;
      p2_d      = p2_q;
      l_overlap = ((puck_y_q + 10'd8) > lpad_q) && (puck_y_q < (lpad_q + 10'd64));
      r_overlap = ((puck_y_q + 10'd8) > rpad_q) && (puck_y_q < (rpad_q + 10'd64));
      vx_next   = vx_neg_q;
      vy_next   = vy_neg_q;
      if (frame_tick) begin
         lpad_d = move_paddle(lpad_q, btnu, btnd);
         rpad_d = move_paddle(rpad_q, btnl, btnr);
         // A goal pre-empts any bounce: the puck is re-served with vy untouched.
         if (puck_x_q <= 10'd8) begin
            p2_d     = score_inc(p2_q);
            puck_x_d = PUCK_X0;
            puck_y_d = PUCK_Y0;
            vx_neg_d = 1'b1;
         end else if (puck_x_q >= 10'd624) begin
            p1_d     = score_inc(p1_q);
            puck_x_d = PUCK_X0;
            puck_y_d = PUCK_Y0;
            vx_neg_d = 1'b0;
         end else begin
            if (vx_neg_q && (puck_x_q >= 10'd16) && (puck_x_q <= 10'd24) && l_overlap)
               vx_next = 1'b0;
            else if (!vx_neg_q && (puck_x_q >= 10'd608) && (puck_x_q <= 10'd616) && r_overlap)
               vx_next = 1'b1;
            if ((vy_neg_q && (puck_y_q <= 10'd8)) || (!vy_neg_q && (puck_y_q >= 10'd464)))
               vy_next = ~vy_neg_q;
            vx_neg_d = vx_next;
            vy_neg_d = vy_next;
            puck_x_d = vx_next ? puck_x_q - 10'd2 : puck_x_q + 10'd2;
            puck_y_d = vy_next ? puck_y_q - 10'd2 : puck_y_q + 10'd2;
         end
      end
   end

   always_comb begin
      active    = (hc_q < 10'd640) && (vc_q < 10'd480);
      in_puck   = (hc_q >= puck_x_q) && (hc_q < puck_x_q + 10'd8) &&
                  (vc_q >= puck_y_q) && (vc_q < puck_y_q + 10'd8);
      in_lpad   = (hc_q >= LPAD_X) && (hc_q < LPAD_X + 10'd8) &&
                  (vc_q >= lpad_q) && (vc_q < lpad_q + 10'd64);
      in_rpad   = (hc_q >= RPAD_X) && (hc_q < RPAD_X + 10'd8) &&
                  (vc_q >= rpad_q) && (vc_q < rpad_q + 10'd64);
      in_border = (hc_q < 10'd8) || (hc_q >= 10'd632) || (vc_q < 10'd8) || (vc_q >= 10'd472);
      red_d     = 3'd0;
      green_d   = 3'd0;
      blue_d    = 2'd0;
      if (active) begin
         if (in_puck) begin
            green_d = 3'b111;
         end else if (in_lpad) begin
            red_d = 3'b111;
         end else if (in_rpad) begin
            blue_d = 2'b11;
         end else if (in_border) begin
            red_d   = 3'b111;
            green_d = 3'b111;
            blue_d  = 2'b11;
         end
      end
      hsync_d = !((hc_q >= 10'd656) && (hc_q <= 10'd751));
      vsync_d = !((vc_q >= 10'd490) && (vc_q <= 10'd491));
   end

   always_comb begin
      scan_d = scan_q + 18'd1;
      an_d   = 4'b1110;
      seg_d  = 8'hFF;
      case (scan_q[17:16])
         2'd0: begin an_d = 4'b1110; seg_d = seg_of(p2_q); end
         2'd1: an_d = 4'b1101;
         2'd2: an_d = 4'b1011;
         2'd3: begin an_d = 4'b0111; seg_d = seg_of(p1_q); end
         default: an_d = 4'b1110;
      endcase
   end

   always_ff @(posedge InputClock) begin
      if (btns) begin
         pix_q    <= 1'b0;
         hc_q     <= 10'd0;
         vc_q     <= 10'd0;
         lpad_q   <= PAD_Y0;
         rpad_q   <= PAD_Y0;
         puck_x_q <= PUCK_X0;
         puck_y_q <= PUCK_Y0;
         vx_neg_q <= 1'b0;
         vy_neg_q <= 1'b0;
         p1_q     <= 4'd0;
         p2_q     <= 4'd0;
         red_q    <= 3'd0;
         green_q  <= 3'd0;
         blue_q   <= 2'd0;
         hsync_q  <= 1'b1;
         vsync_q  <= 1'b1;
         scan_q   <= 18'd0;
         seg_q    <= 8'hC0;
         an_q     <= 4'b1110;
      end else begin
         pix_q    <= pix_d;
         hc_q     <= hc_d;
         vc_q     <= vc_d;
         lpad_q   <= lpad_d;
         rpad_q   <= rpad_d;
         puck_x_q <= puck_x_d;
         puck_y_q <= puck_y_d;
         vx_neg_q <= vx_neg_d;
         vy_neg_q <= vy_neg_d;
         p1_q     <= p1_d;
         p2_q     <= p2_d;
         red_q    <= red_d;
         green_q  <= green_d;
         blue_q   <= blue_d;
         hsync_q  <= hsync_d;
         vsync_q  <= vsync_d;
         scan_q   <= scan_d;
         seg_q    <= seg_d;
         an_q     <= an_d;
      end
   end

   assign red   = red_q;
   assign green = green_q;
   assign blue  = blue_q;
   assign hsync = hsync_q;
   assign vsync = vsync_q;
   assign seg   = seg_q;
   assign an    = an_q;

endmodule

// File: tb/tb_air_hockey.sv
// Directed bench for air_hockey; game frames are reached quickly by jumping the
// raster counters to just before the frame tick.
module tb_air_hockey;
   logic       clk = 1'b0;
   logic       btns = 1'b0, btnu = 1'b0, btnd = 1'b0, btnl = 1'b0, btnr = 1'b0;
   logic [2:0] red, green;
   logic [1:0] blue;
   logic       hsync, vsync;
   logic [7:0] seg;
   logic [3:0] an;
   int         total = 0;
   int         bad = 0;

   logic [9:0]  f_x, f_y;
   logic        f_vxn, f_vyn;
   logic [17:0] f_scan;

   air_hockey dut (
      .InputClock(clk), .btns(btns), .btnu(btnu), .btnd(btnd), .btnl(btnl), .btnr(btnr),
      .red(red), .green(green), .blue(blue), .hsync(hsync), .vsync(vsync),
      .seg(seg), .an(an)
   );

   always #10 clk = ~clk;

   task do_reset();
      @(negedge clk);
      btns = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      btns = 1'b0;
   endtask

   task step_frames(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         force dut.hc_q = 10'd630;
         force dut.vc_q = 10'd479;
         @(posedge clk);
         @(negedge clk);
         release dut.hc_q;
         release dut.vc_q;
         repeat (30) @(negedge clk);
      end
   endtask

   task set_puck(input logic [9:0] x, input logic [9:0] y, input logic vxn, input logic vyn);
      f_x = x; f_y = y; f_vxn = vxn; f_vyn = vyn;
      @(negedge clk);
      force dut.puck_x_q = f_x;
      force dut.puck_y_q = f_y;
      force dut.vx_neg_q = f_vxn;
      force dut.vy_neg_q = f_vyn;
      @(posedge clk);
      @(negedge clk);
      release dut.puck_x_q;
      release dut.puck_y_q;
      release dut.vx_neg_q;
      release dut.vy_neg_q;
   endtask

   task set_scan(input logic [17:0] v);
      f_scan = v;
      @(negedge clk);
      force dut.scan_q = f_scan;
      @(posedge clk);
      @(negedge clk);
      release dut.scan_q;
   endtask

   task test_reset();
      int n, m;
      logic seen_high;
      @(negedge clk);
      btns = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      total++; if ({red, green, blue} !== 8'h00) begin bad++; $display("FAIL reset_rgb got %h want 00", {red, green, blue}); end
      total++; if ({hsync, vsync} !== 2'b11) begin bad++; $display("FAIL reset_sync got %b want 11", {hsync, vsync}); end
      total++; if (an !== 4'b1110) begin bad++; $display("FAIL reset_an got %b want 1110", an); end
      total++; if (seg !== 8'hC0) begin bad++; $display("FAIL reset_seg got %h want C0", seg); end
      btns = 1'b0;
      n = 0;
      while (n < 3000) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (n == 1) begin
            total++; if ({red, green, blue} !== 8'hFF) begin bad++; $display("FAIL corner_white got %h want FF", {red, green, blue}); end
         end
         if (hsync == 1'b0) break;
      end
      total++; if (n != 1313) begin bad++; $display("FAIL hsync_first_fall got %0d want 1313", n); end
      m = 0;
      seen_high = 1'b0;
      while (m < 3000) begin
         @(posedge clk);
         m++;
         @(negedge clk);
         if (hsync == 1'b1) seen_high = 1'b1;
         else if (seen_high) break;
      end
      total++; if (m != 1600) begin bad++; $display("FAIL hsync_period got %0d want 1600", m); end
   endtask

   task test_vsync();
      int n, low;
      @(negedge clk);
      force dut.hc_q = 10'd795;
      force dut.vc_q = 10'd489;
      @(posedge clk);
      @(negedge clk);
      release dut.hc_q;
      release dut.vc_q;
      n = 0;
      while (vsync !== 1'b0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      low = 0;
      while (vsync === 1'b0 && low < 5000) begin
         low++;
         @(negedge clk);
      end
      total++; if (low != 3200) begin bad++; $display("FAIL vsync_low got %0d want 3200", low); end
   endtask

   task test_idle();
      do_reset();
      step_frames(10);
      total++; if (dut.puck_x_q !== 10'd336) begin bad++; $display("FAIL idle_x got %0d want 336", dut.puck_x_q); end
      total++; if (dut.puck_y_q !== 10'd256) begin bad++; $display("FAIL idle_y got %0d want 256", dut.puck_y_q); end
      total++; if (dut.lpad_q !== 10'd208 || dut.rpad_q !== 10'd208) begin bad++; $display("FAIL idle_pads got %0d/%0d want 208/208", dut.lpad_q, dut.rpad_q); end
   endtask

   task test_paddles();
      btnu = 1'b1;
      step_frames(60);
      total++; if (dut.lpad_q !== 10'd8) begin bad++; $display("FAIL lpad_top got %0d want 8", dut.lpad_q); end
      btnd = 1'b1;
      step_frames(3);
      total++; if (dut.lpad_q !== 10'd8) begin bad++; $display("FAIL lpad_both got %0d want 8", dut.lpad_q); end
      btnu = 1'b0;
      step_frames(2);
      total++; if (dut.lpad_q !== 10'd16) begin bad++; $display("FAIL lpad_down got %0d want 16", dut.lpad_q); end
      btnd = 1'b0;
      btnr = 1'b1;
      step_frames(3);
      total++; if (dut.rpad_q !== 10'd220) begin bad++; $display("FAIL rpad_down got %0d want 220", dut.rpad_q); end
      step_frames(60);
      total++; if (dut.rpad_q !== 10'd408) begin bad++; $display("FAIL rpad_bottom got %0d want 408", dut.rpad_q); end
      btnr = 1'b0;
   endtask

   task test_left_goal();
      do_reset();
      set_puck(10'd12, 10'd100, 1'b1, 1'b0);
      step_frames(2);
      total++; if (dut.puck_x_q !== 10'd8 || dut.p2_q !== 4'd0) begin bad++; $display("FAIL pre_goal got x=%0d p2=%0d want x=8 p2=0", dut.puck_x_q, dut.p2_q); end
      step_frames(1);
      total++; if (dut.puck_x_q !== 10'd316 || dut.puck_y_q !== 10'd236) begin bad++; $display("FAIL goal_serve_pos got %0d,%0d want 316,236", dut.puck_x_q, dut.puck_y_q); end
      total++; if (dut.vx_neg_q !== 1'b1 || dut.vy_neg_q !== 1'b0) begin bad++; $display("FAIL goal_serve_vel got vxn=%b vyn=%b want 1 0", dut.vx_neg_q, dut.vy_neg_q); end
      set_scan(18'h00000);
      total++; if (an !== 4'b1110 || seg !== 8'hF9) begin bad++; $display("FAIL p2_digit got an=%b seg=%h want 1110 F9", an, seg); end
      set_scan(18'h10000);
      total++; if (an !== 4'b1101 || seg !== 8'hFF) begin bad++; $display("FAIL blank_digit got an=%b seg=%h want 1101 FF", an, seg); end
   endtask

   task test_paddle_hit();
      set_puck(10'd26, 10'd220, 1'b1, 1'b0);
      step_frames(2);
      total++; if (dut.vx_neg_q !== 1'b0) begin bad++; $display("FAIL lpad_hit_vx got vxn=%b want 0", dut.vx_neg_q); end
      total++; if (dut.puck_x_q !== 10'd26 || dut.puck_y_q !== 10'd224) begin bad++; $display("FAIL lpad_hit_pos got %0d,%0d want 26,224", dut.puck_x_q, dut.puck_y_q); end
      total++; if (dut.p1_q !== 4'd0 || dut.p2_q !== 4'd1) begin bad++; $display("FAIL lpad_hit_score got %0d/%0d want 0/1", dut.p1_q, dut.p2_q); end
   endtask

   task test_walls();
      set_puck(10'd300, 10'd8, 1'b0, 1'b1);
      step_frames(1);
      total++; if (dut.vy_neg_q !== 1'b0 || dut.puck_y_q !== 10'd10 || dut.puck_x_q !== 10'd302) begin bad++; $display("FAIL top_bounce got vyn=%b y=%0d x=%0d want 0 10 302", dut.vy_neg_q, dut.puck_y_q, dut.puck_x_q); end
      set_puck(10'd624, 10'd464, 1'b0, 1'b0);
      step_frames(1);
      total++; if (dut.p1_q !== 4'd1 || dut.puck_x_q !== 10'd316 || dut.puck_y_q !== 10'd236) begin bad++; $display("FAIL goal_wins got p1=%0d pos=%0d,%0d want 1 316,236", dut.p1_q, dut.puck_x_q, dut.puck_y_q); end
      total++; if (dut.vx_neg_q !== 1'b0 || dut.vy_neg_q !== 1'b0) begin bad++; $display("FAIL goal_wins_vel got vxn=%b vyn=%b want 0 0", dut.vx_neg_q, dut.vy_neg_q); end
   endtask

   task test_p1_wrap();
      do_reset();
      for (int g = 1; g <= 10; g++) begin
         set_puck(10'd624, 10'd100, 1'b0, 1'b0);
         step_frames(1);
         if (g == 9) begin
            set_scan(18'h30000);
            total++; if (an !== 4'b0111 || seg !== 8'h90) begin bad++; $display("FAIL p1_nine got an=%b seg=%h want 0111 90", an, seg); end
         end
      end
      set_scan(18'h30000);
      total++; if (an !== 4'b0111 || seg !== 8'hC0) begin bad++; $display("FAIL p1_wrap got an=%b seg=%h want 0111 C0", an, seg); end
      total++; if (dut.p2_q !== 4'd0) begin bad++; $display("FAIL p1_wrap_p2 got %0d want 0", dut.p2_q); end
   endtask

   initial begin
      test_reset();
      test_vsync();
      test_idle();
      test_paddles();
      test_left_goal();
      test_paddle_hit();
      test_walls();
      test_p1_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
